// File: rtl/jtframe_rom_pkg.sv
// Shared types and helpers for the four-slot SDRAM ROM arbiter.
// Holds slot count, default widths, FSM states and the round-robin pick.
package jtframe_rom_pkg;

  localparam int SLOTS  = 4;
  localparam int AW_DEF = 22;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DATA = 2'd2
  } rom_st_e;

  // First set bit of req searching from ptr+1; ptr itself is checked last
  function automatic logic [1:0] rr_next(
    input logic [3:0] req,
    input logic [1:0] ptr
  );
    logic [1:0] g;
    logic [1:0] c;
    g = ptr;
    for (int k = 4; k >= 1; k--) begin
      c = ptr + 2'(k);
      if (req[c]) g = c;
    end
    return g;
  endfunction

endpackage

// File: rtl/jtframe_rom_slot.sv
// One-word ROM cache entry: valid/tag/data, hit compare,
// fill port and flush input.
module jtframe_rom_slot
  import jtframe_rom_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          fill,
  input  logic [AW-1:0] addr,
  input  logic [AW-1:0] fill_tag,
  input  logic [DW-1:0] fill_data,
  output logic          hit,
  output logic [DW-1:0] dout
);

  logic          valid;
  logic [AW-1:0] tag;

  // Flush masks the hit in the same cycle it is raised
  assign hit = valid & ~flush & (tag == addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      dout  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (fill) begin
      valid <= 1'b1;
      tag   <= fill_tag;
      dout  <= fill_data;
    end
  end

endmodule

// File: rtl/jtframe_rom_arb.sv
// Four-slot round-robin arbiter sharing the SDRAM ROM read port,
// with a one-word cache per requester.
module jtframe_rom_arb
  import jtframe_rom_pkg::*;
#(
  parameter int          AW      = AW_DEF,
  parameter int          DW      = DW_DEF,
  parameter logic [AW-1:0] OFFSET0 = '0,
  parameter logic [AW-1:0] OFFSET1 = '0,
  parameter logic [AW-1:0] OFFSET2 = '0,
  parameter logic [AW-1:0] OFFSET3 = '0
) (
  input  logic               rst,
  input  logic               clk_rom,
  input  logic               downloading,
  input  logic [3:0]         slot_cs,
  input  logic [4*AW-1:0]    slot_addr,
  output logic [3:0]         slot_ok,
  output logic [4*DW-1:0]    slot_dout,
  output logic               sdram_req,
  output logic [AW-1:0]      sdram_addr,
  input  logic               sdram_ack,
  input  logic               data_rdy,
  input  logic [DW-1:0]      data_read
);

  rom_st_e       st, st_nx;
  logic [1:0]    ptr, ptr_nx;
  logic [1:0]    gnt, gnt_nx;
  logic [AW-1:0] gnt_addr, gaddr_nx;
  logic          req_nx;
  logic [AW-1:0] saddr_nx;
  logic          fill_en;
  logic [1:0]    pick;
  logic [AW-1:0] off;
  logic [3:0]    hit;
  logic [3:0]    miss;
  logic [AW-1:0] addr_a [SLOTS];

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    assign addr_a[i] = slot_addr[i*AW +: AW];
    jtframe_rom_slot #(.AW(AW), .DW(DW)) u_slot (
      .clk       (clk_rom),
      .rst       (rst),
      .flush     (downloading),
      .fill      (fill_en && (gnt == 2'(i))),
      .addr      (addr_a[i]),
      .fill_tag  (gnt_addr),
      .fill_data (data_read),
      .hit       (hit[i]),
      .dout      (slot_dout[i*DW +: DW])
    );
  end

  assign slot_ok = slot_cs & hit;
  assign miss    = slot_cs & ~hit;
  assign pick    = rr_next(miss, ptr);

  always_comb begin
    off = OFFSET0;
    unique case (pick)
      2'd0: off = OFFSET0;
      2'd1: off = OFFSET1;
      2'd2: off = OFFSET2;
      2'd3: off = OFFSET3;
    endcase
  end

  always_comb begin
    st_nx    = st;
    ptr_nx   = ptr;
    gnt_nx   = gnt;
    gaddr_nx = gnt_addr;
    req_nx   = sdram_req;
    saddr_nx = sdram_addr;
    fill_en  = 1'b0;
    if (downloading) begin
      st_nx  = IDLE;
      req_nx = 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (|miss) begin
            gnt_nx   = pick;
            gaddr_nx = addr_a[pick];
            saddr_nx = addr_a[pick] + off;
            req_nx   = 1'b1;
            st_nx    = WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (sdram_ack) begin
            req_nx = 1'b0;
            if (data_rdy) begin
              fill_en = 1'b1;
              ptr_nx  = gnt;
              st_nx   = IDLE;
            end else begin
              st_nx = WAIT_DATA;
            end
          end
        end
        WAIT_DATA: begin
          if (data_rdy) begin
            fill_en = 1'b1;
            ptr_nx  = gnt;
            st_nx   = IDLE;
          end
        end
        default: st_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      st         <= IDLE;
      ptr        <= 2'd3;
      gnt        <= 2'd0;
      gnt_addr   <= '0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
    end else begin
      st         <= st_nx;
      ptr        <= ptr_nx;
      gnt        <= gnt_nx;
      gnt_addr   <= gaddr_nx;
      sdram_req  <= req_nx;
      sdram_addr <= saddr_nx;
    end
  end

endmodule

// File: tb/tb_jtframe_rom_arb.sv
// Scoreboard bench for jtframe_rom_arb: SDRAM model with a
// memory function, per-slot expected-data queues and directed phases.
module tb_jtframe_rom_arb;

  localparam int AW = 22;
  localparam int DW = 32;
  localparam logic [21:0] O0 = 22'h20000;
  localparam logic [21:0] O1 = 22'h01000;
  localparam logic [21:0] O2 = 22'h3FFFF0;
  localparam logic [21:0] O3 = 22'h00000;

  logic           rst;
  logic           clk_rom = 1'b0;
  logic           downloading;
  logic [3:0]     slot_cs;
  logic [4*AW-1:0] slot_addr;
  logic [3:0]     slot_ok;
  logic [4*DW-1:0] slot_dout;
  logic           sdram_req;
  logic [AW-1:0]  sdram_addr;
  logic           sdram_ack;
  logic           data_rdy;
  logic [DW-1:0]  data_read;

  logic ctl_en;
  int   same_mode;
  logic man_ack, man_rdy, c_ack, c_rdy;
  logic [DW-1:0] man_data, c_data;

  assign sdram_ack = ctl_en ? c_ack : man_ack;
  assign data_rdy  = ctl_en ? c_rdy : man_rdy;
  assign data_read = ctl_en ? c_data : man_data;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] exp_q [4][$];
  logic [21:0] req_q [$];

  jtframe_rom_arb #(
    .AW(AW), .DW(DW),
    .OFFSET0(O0), .OFFSET1(O1), .OFFSET2(O2), .OFFSET3(O3)
  ) dut (
    .rst(rst), .clk_rom(clk_rom), .downloading(downloading),
    .slot_cs(slot_cs), .slot_addr(slot_addr),
    .slot_ok(slot_ok), .slot_dout(slot_dout),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr),
    .sdram_ack(sdram_ack), .data_rdy(data_rdy),
    .data_read(data_read)
  );

  always #5 clk_rom = ~clk_rom;

  function automatic logic [31:0] mem(input logic [21:0] a);
    return {a[9:0], a} ^ 32'hA5C3_0F1E;
  endfunction

  function automatic logic [21:0] offs(input int s);
    case (s)
      0: return O0;
      1: return O1;
      2: return O2;
      default: return O3;
    endcase
  endfunction

  function automatic logic [21:0] absa(input int s, input logic [21:0] a);
    return a + offs(s);
  endfunction

  task automatic tick();
    @(posedge clk_rom);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic set_addr(input int s, input logic [21:0] a);
    slot_addr[s*AW +: AW] = a;
  endtask

  // New request for slot s: expect the model memory at the absolute address
  task automatic expect_slot(input int s, input logic [21:0] a,
                             input bit reqchk);
    exp_q[s].push_back(mem(absa(s, a)));
    if (reqchk) req_q.push_back(absa(s, a));
    set_addr(s, a);
  endtask

  function automatic int pending();
    return exp_q[0].size() + exp_q[1].size()
         + exp_q[2].size() + exp_q[3].size();
  endfunction

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (pending() != 0 && n < 400) begin
      tick();
      n++;
    end
    vectors++;
    if (pending() != 0) begin
      miscompares++;
      $display("FAIL %s timeout pending=%0d exp=0", nm, pending());
      for (int i = 0; i < 4; i++) exp_q[i].delete();
    end
  endtask

  task automatic wait_req(input string nm);
    int n;
    n = 0;
    while (!sdram_req && n < 20) begin
      @(negedge clk_rom);
      n++;
    end
    chk(nm, 128'(sdram_req), 128'(1));
  endtask

  // Monitor: compares each slot's data when it reports a hit
  logic [31:0] mon_e;
  always @(negedge clk_rom) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst && slot_ok[i] && exp_q[i].size() > 0) begin
        mon_e = exp_q[i].pop_front();
        vectors++;
        if (slot_dout[i*DW +: DW] !== mon_e) begin
          miscompares++;
          $display("FAIL slot%0d_data got=%h exp=%h",
                   i, slot_dout[i*DW +: DW], mon_e);
        end
      end
    end
  end

  // SDRAM controller model with random ack/data latencies
  logic [21:0] ca, ce;
  bit sc;
  initial begin
    c_ack = 1'b0;
    c_rdy = 1'b0;
    c_data = '0;
    forever begin
      tick();
      c_ack = 1'b0;
      c_rdy = 1'b0;
      if (ctl_en && sdram_req && !rst) begin
        ca = sdram_addr;
        if (req_q.size() > 0) begin
          ce = req_q.pop_front();
          vectors++;
          if (ca !== ce) begin
            miscompares++;
            $display("FAIL req_addr got=%h exp=%h", ca, ce);
          end
        end
        repeat ($urandom_range(0, 2)) tick();
        c_ack = 1'b1;
        sc = (same_mode == 1) ||
             (same_mode == 2 && $urandom_range(0, 1) == 1);
        if (sc) begin
          c_rdy = 1'b1;
          c_data = mem(ca);
        end
        tick();
        c_ack = 1'b0;
        c_rdy = 1'b0;
        if (sc) begin
          vectors++;
          if (sdram_req !== 1'b0) begin
            miscompares++;
            $display("FAIL same_cycle_req got=%b exp=0", sdram_req);
          end
        end else begin
          repeat ($urandom_range(1, 4)) tick();
          c_rdy = 1'b1;
          c_data = mem(ca);
          tick();
          c_rdy = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit bad;
    logic [3:0] m;
    rst = 1'b1;
    downloading = 1'b0;
    slot_cs = '0;
    slot_addr = '0;
    man_ack = 1'b0;
    man_rdy = 1'b0;
    man_data = '0;
    ctl_en = 1'b0;
    same_mode = 0;
    repeat (3) tick();
    chk("reset_ok", 128'(slot_ok), 128'(0));
    chk("reset_dout", slot_dout, 128'(0));
    chk("reset_req", 128'({sdram_req, sdram_addr}), 128'(0));
    rst = 1'b0;
    tick();

    // Round-robin: all four miss, then slot 0 re-misses during slot 3
    ctl_en = 1'b1;
    for (int i = 0; i < 4; i++) expect_slot(i, 22'h10 + 22'(i), 1'b1);
    slot_cs = 4'hF;
    n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0
           && n < 300) begin
      tick();
      n++;
    end
    expect_slot(0, 22'h20, 1'b1);
    drain("rr_drain");
    chk("rr_reqq_empty", 128'(req_q.size()), 128'(0));
    slot_cs = '0;
    repeat (3) tick();
    ctl_en = 1'b0;

    // Miss then hit with manual handshake
    set_addr(0, 22'h100);
    slot_cs = 4'b0001;
    @(negedge clk_rom);
    chk("mh_req_latency", 128'(sdram_req), 128'(0));
    tick();
    chk("mh_req", 128'({sdram_req, sdram_addr}), 128'({1'b1, 22'h20100}));
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    chk("mh_req_drop", 128'(sdram_req), 128'(0));
    repeat (3) tick();
    chk("mh_ok_wait", 128'(slot_ok[0]), 128'(0));
    man_rdy = 1'b1;
    man_data = 32'hDEADBEEF;
    tick();
    man_rdy = 1'b0;
    chk("mh_ok", 128'(slot_ok[0]), 128'(1));
    chk("mh_dout", 128'(slot_dout[31:0]), 128'(32'hDEADBEEF));
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (sdram_req || !slot_ok[0]) bad = 1'b1;
    end
    chk("mh_rehit", 128'(bad), 128'(0));
    slot_cs = '0;
    tick();
    chk("mh_hold", 128'({slot_ok[0], slot_dout[31:0]}),
        128'({1'b0, 32'hDEADBEEF}));

    // Address change while the fetch is in flight
    ctl_en = 1'b1;
    set_addr(1, 22'h40);
    req_q.push_back(absa(1, 22'h40));
    slot_cs = 4'b0010;
    n = 0;
    while (!sdram_ack && n < 30) begin
      @(negedge clk_rom);
      n++;
    end
    tick();
    expect_slot(1, 22'h41, 1'b1);
    n = 0;
    while (!data_rdy && n < 30) begin
      @(negedge clk_rom);
      n++;
    end
    @(negedge clk_rom);
    chk("chg_ok_low", 128'(slot_ok[1]), 128'(0));
    drain("chg_drain");
    chk("chg_reqq_empty", 128'(req_q.size()), 128'(0));

    // ack and data_rdy together, plus offset wrap and max address
    same_mode = 1;
    expect_slot(2, 22'h20, 1'b1);
    slot_cs = 4'b0100;
    drain("same_drain2");
    expect_slot(3, 22'h3FFFFF, 1'b1);
    slot_cs = 4'b1000;
    drain("same_drain3");
    chk("same_reqq_empty", 128'(req_q.size()), 128'(0));
    same_mode = 0;
    slot_cs = '0;
    repeat (3) tick();
    ctl_en = 1'b0;

    // Download flush during WAIT_DATA; late data discarded
    set_addr(0, 22'h200);
    set_addr(1, 22'h41);
    slot_cs = 4'b0011;
    @(negedge clk_rom);
    chk("fl_pre_ok", 128'(slot_ok), 128'(4'b0010));
    tick();
    chk("fl_req", 128'({sdram_req, sdram_addr}), 128'({1'b1, 22'h20200}));
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    downloading = 1'b1;
    @(negedge clk_rom);
    chk("fl_ok_drop", 128'(slot_ok), 128'(0));
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (sdram_req) bad = 1'b1;
    end
    chk("fl_no_grant", 128'(bad), 128'(0));
    downloading = 1'b0;
    man_rdy = 1'b1;
    man_data = 32'hBAD0BAD0;
    tick();
    man_rdy = 1'b0;
    @(negedge clk_rom);
    chk("fl_late_data", 128'(slot_ok), 128'(0));
    vectors++;
    if (!(sdram_req && (sdram_addr == 22'h20200 ||
                        sdram_addr == absa(1, 22'h41)))) begin
      miscompares++;
      $display("FAIL fl_rereq got=%b/%h exp=1/%h", sdram_req, sdram_addr,
               22'h20200);
    end
    exp_q[0].push_back(mem(22'h20200));
    exp_q[1].push_back(mem(absa(1, 22'h41)));
    ctl_en = 1'b1;
    drain("fl_drain");

    // Randomized traffic over a small address window
    same_mode = 2;
    for (int t = 0; t < 60; t++) begin
      m = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++)
        if (m[i]) expect_slot(i, 22'($urandom_range(0, 5)), 1'b0);
      slot_cs = m;
      drain("rnd_drain");
      if ($urandom_range(0, 3) == 0) begin
        slot_cs = '0;
        tick();
      end
    end
    same_mode = 0;
    slot_cs = '0;
    repeat (3) tick();
    ctl_en = 1'b0;

    // Asynchronous reset in WAIT_ACK
    set_addr(2, 22'h30);
    slot_cs = 4'b0100;
    wait_req("rst_pre_req");
    @(negedge clk_rom);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_req", 128'(sdram_req), 128'(0));
    chk("rst_ok", 128'({slot_ok, slot_dout}), 128'(0));
    @(negedge clk_rom);
    for (int i = 0; i < 4; i++) expect_slot(i, 22'h50 + 22'(i), 1'b1);
    slot_cs = 4'hF;
    rst = 1'b0;
    tick();
    chk("rst_first_gnt", 128'({sdram_req, sdram_addr}),
        128'({1'b1, absa(0, 22'h50)}));
    ctl_en = 1'b1;
    drain("rst_drain");
    chk("rst_reqq_empty", 128'(req_q.size()), 128'(0));
    slot_cs = '0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
